// File: rtl/apb_slave_regfile_if.sv
// APB completer link: requester-driven bus signals and completer responses.
// prot_err is carried here as a sideband status alongside the response.
interface apb_slave_regfile_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;
  logic              prot_err;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr, prot_err
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr, prot_err
  );
endinterface

// File: rtl/apb_slave_regfile.sv
// APB completer with DEPTH x DATA_W register file, range error, abort flag.
// Define APB_SLV_WAIT_EN to insert WAIT_CYCLES wait states per transfer.
module apb_slave_regfile #(
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input logic                pclk,
  input logic                preset,
  apb_slave_regfile_if.slave bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15 ||
      DEPTH > 2 ** (ADDR_W - 1)) begin : g_bad_cfg
    $error("apb_slave_regfile: illegal parameters");
  end

`ifdef APB_SLV_WAIT_EN
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES);
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_READY = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READY = 2'd2
  } state_t;
`endif

  state_t state_q, state_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [IDX_W-1:0]  idx_q;
  logic              wr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              err_q;

  logic              pready_q, pready_d;
  logic              pslverr_q, pslverr_d;
  logic [DATA_W-1:0] prdata_q, prdata_d;
  logic              prot_err_q, prot_err_d;

`ifdef APB_SLV_WAIT_EN
  logic [3:0] cnt_q, cnt_d;
`endif

  logic             setup;
  logic             access;
  logic             from_idle;
  logic             latch;
  logic             go_ready;
  logic             mem_we;
  logic [IDX_W-1:0] cur_idx;
  logic             cur_wr;
  logic             cur_err;

  assign setup     = bus.psel & ~bus.penable;
  assign access    = bus.psel & bus.penable;
  assign from_idle = (state_q == S_IDLE);

  // Response source: live bus when completing straight out of IDLE
  assign cur_idx = from_idle ? bus.paddr[IDX_W-1:0] : idx_q;
  assign cur_wr  = from_idle ? bus.pwrite : wr_q;
  assign cur_err = from_idle ? (bus.paddr >= DEPTH_A) : err_q;

  // Next-state and next-response logic
  always_comb begin
    state_d    = state_q;
    pready_d   = 1'b0;
    pslverr_d  = 1'b0;
    prdata_d   = '0;
    prot_err_d = prot_err_q;
    latch      = 1'b0;
    go_ready   = 1'b0;
    mem_we     = 1'b0;
`ifdef APB_SLV_WAIT_EN
    cnt_d      = cnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (setup) begin
          latch = 1'b1;
`ifdef APB_SLV_WAIT_EN
          if (CNT_INIT == 4'd0) begin
            go_ready = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
`else
          go_ready = 1'b1;
`endif
        end
      end
`ifdef APB_SLV_WAIT_EN
      S_WAIT: begin
        if (access) begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            go_ready = 1'b1;
          end
        end else begin
          state_d    = S_IDLE;
          prot_err_d = 1'b1;
        end
      end
`endif
      S_READY: begin
        state_d = S_IDLE;
        if (access) begin
          mem_we = wr_q & ~err_q;
        end else begin
          prot_err_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (go_ready) begin
      state_d   = S_READY;
      pready_d  = 1'b1;
      pslverr_d = cur_err;
      if (!cur_wr && !cur_err) begin
        prdata_d = mem[cur_idx];
      end
    end
  end

  // State, transfer latch and registered response
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      wr_q       <= 1'b0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      pready_q   <= 1'b0;
      pslverr_q  <= 1'b0;
      prdata_q   <= '0;
      prot_err_q <= 1'b0;
`ifdef APB_SLV_WAIT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      pready_q   <= pready_d;
      pslverr_q  <= pslverr_d;
      prdata_q   <= prdata_d;
      prot_err_q <= prot_err_d;
`ifdef APB_SLV_WAIT_EN
      cnt_q      <= cnt_d;
`endif
      if (latch) begin
        idx_q   <= bus.paddr[IDX_W-1:0];
        wr_q    <= bus.pwrite;
        wdata_q <= bus.pwdata;
        err_q   <= (bus.paddr >= DEPTH_A);
      end
    end
  end

  // Register file: cleared on reset, written as the READY cycle closes
  always_ff @(posedge pclk) begin
    if (preset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (mem_we) begin
      mem[idx_q] <= wdata_q;
    end
  end

  assign bus.prdata   = prdata_q;
  assign bus.pready   = pready_q;
  assign bus.pslverr  = pslverr_q;
  assign bus.prot_err = prot_err_q;

endmodule

// File: doc/apb_slave_regfile.md
# apb_slave_regfile

APB completer that terminates transfers issued by the APB master: decodes `paddr`, services reads and writes against an internal register file, inserts programmable wait states, and signals `pslverr` on out-of-range accesses. It sits on the peripheral side of the APB link and serves as both the functional target and the verification partner for the master.

## Interface
Parameters:
- `ADDR_W`, 9: width of `paddr`.
- `DATA_W`, 8: width of `pwdata`/`prdata`.
- `DEPTH`, 256: number of register words. Must satisfy DEPTH ≤ 2^(ADDR_W-1).
- `WAIT_CYCLES`, 2: `pready`-low access cycles per transfer (0..15). Used only with `APB_SLV_WAIT_EN`.

Ports (one clock; reset is synchronous and active-high):
- `pclk`  in  1  APB clock; all state changes on its rising edge.
- `preset`  in  1  synchronous active-high reset.
- `psel`  in  1  slave select from the master.
- `penable`  in  1  access-phase strobe.
- `pwrite`  in  1  1 = write, 0 = read.
- `paddr`  in  ADDR_W  word address.
- `pwdata`  in  DATA_W  write data.
- `prdata`  out  DATA_W  read data; valid while `pready`=1 on a read.
- `pready`  out  1  transfer-complete strobe, registered.
- `pslverr`  out  1  error response; valid only while `pready`=1.
- `prot_err`  out  1  sticky flag: the master abandoned a transfer mid-access. Cleared only by reset.

## Operation
- Register file: DEPTH × DATA_W flops, all cleared to 0 on reset.
- FSM states:
  - IDLE: reached from reset.
  - WAIT: counting wait states.
  - READY: `pready`=1.
- IDLE, at an edge with `psel`=1 and `penable`=0 (setup cycle):
  - Latch `paddr`, `pwrite`, `pwdata`.
  - Compute `err = (paddr >= DEPTH)`.
  - If the effective wait count is 0, go to READY. Otherwise go to WAIT with `cnt` = WAIT_CYCLES.
- WAIT:
  - At each edge with `psel`=1 and `penable`=1, decrement `cnt`.
  - When `cnt`=1, go to READY.
- Entry to READY (same edge):
  - `pready`<=1 and `pslverr`<=err.
  - `prdata`<=mem[addr] for a read without error. Otherwise `prdata`<=0.
- READY, at the next edge:
  - If the latched `pwrite`=1 and err=0, write mem[addr]<=latched `pwdata`.
  - Clear `pready`, `pslverr`, `prdata` to 0. Go to IDLE.
- Erroneous writes never modify the register file. Erroneous reads return 0.
- Abort: if `psel`=0 or `penable`=0 is sampled in WAIT or READY:
  - Go to IDLE. No write occurs.
  - Clear `pready`, `pslverr`, `prdata`. Set `prot_err`<=1.
- IDLE ignores `penable`=1 without a preceding setup cycle; no response is given.
- Address width rule: compare the full ADDR_W bits against DEPTH. Indexing uses the low $clog2(DEPTH) bits only after the range check passes.

## Timing
- Reset values: `prdata`=0, `pready`=0, `pslverr`=0, `prot_err`=0, state=IDLE, `cnt`=0, register file all 0.
- Reset mid-transfer wins over everything. It discards the pending write, and the next cycle is IDLE.
- Let T0 be the setup cycle and T1 the first access cycle.
  - `pready` is high exactly in cycle T1+W, where W is the effective wait count.
  - Total transfer length is 2+W cycles.
- The write commits at the rising edge ending cycle T1+W. A read issued in the following transfer sees the new value.
- Back-to-back transfers work as follows:
  - The slave is in IDLE in the cycle after `pready`.
  - If that cycle is the master's next setup cycle, the slave accepts it with no bubble.
- `pready` is held high for exactly one cycle per transfer.

## Configuration
- `APB_SLV_WAIT_EN` defined: the effective wait count is WAIT_CYCLES and the WAIT state/counter are compiled in.
- `APB_SLV_WAIT_EN` undefined: the effective wait count is 0, the WAIT state and `cnt` are absent, and every transfer completes in 2 cycles.

## Test plan
- Write, then read, with waits enabled:
  - Stimulus: write 0xA5 to addr 0x10, then read addr 0x10 (WAIT_CYCLES=2).
  - Response: `pready` high in the 3rd access cycle each time, `prdata`=0xA5, `pslverr`=0.
- Out-of-range write:
  - Stimulus: write 0x3C to addr 0x100 (DEPTH=256).
  - Response: `pslverr`=1 with `pready`; a subsequent read of addr 0x00 returns 0x00.
- Back-to-back transfers, waits compiled out:
  - Stimulus: four consecutive writes to 0x01..0x04, each setup immediately after the previous `pready`.
  - Response: each transfer takes 2 cycles; readback gives the written values.
- Abort:
  - Stimulus: drop `psel` in the 1st WAIT cycle of a write of 0xFF to addr 0x20.
  - Response: `prot_err`=1, `pready` never asserted, addr 0x20 still reads 0x00.
- Reset mid-transfer:
  - Stimulus: assert `preset` for one cycle during WAIT of a write of 0x77 to addr 0x05.
  - Response: all outputs 0 next cycle, `prot_err`=0, addr 0x05 reads 0x00.
